// File: rtl/rgb_leds_pkg.sv
// Shared types and constants for the RGB status-LED bank.
// The optional breathe ramp is enabled by defining RGB_LEDS_BREATHE_EN.
package rgb_leds_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_t;

  // Colour bits are {B,G,R}
  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_RED     = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_YELLOW  = 3'b011;
  localparam logic [2:0] COLOR_BLUE    = 3'b100;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_CYAN    = 3'b110;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

  typedef struct packed {
    logic [2:0] color;
    led_mode_t  mode;
  } led_cfg_t;

endpackage

// File: rtl/rgb_pwm_timebase.sv
// Shared PWM counter, blink prescaler/phase and, with RGB_LEDS_BREATHE_EN defined,
// the triangle breathe level used by every LED in the bank.
module rgb_pwm_timebase
  import rgb_leds_pkg::*;
#(
  parameter int PWM_BITS  = 4,
  parameter int BLINK_DIV = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                blink_phase
`ifdef RGB_LEDS_BREATHE_EN
  ,
  output logic [PWM_BITS-1:0] level
`endif
);

  localparam int PS_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(BLINK_DIV - 1);

  logic [PS_W-1:0] prescaler;
  logic            tick;

  assign tick = (prescaler == PS_LAST);

  // PWM period is one short of 2^PWM_BITS so full brightness stays lit every clock
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt     <= '0;
      prescaler   <= '0;
      blink_phase <= 1'b1;
    end else begin
      pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        blink_phase <= ~blink_phase;
      end
    end
  end

`ifdef RGB_LEDS_BREATHE_EN
  logic dir_down;

  // Each extreme is held for one step while the direction flips
  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= '0;
      dir_down <= 1'b0;
    end else if (tick) begin
      if (!dir_down) begin
        if (level == '1) begin
          dir_down <= 1'b1;
        end else begin
          level <= level + 1'b1;
        end
      end else begin
        if (level == '0) begin
          dir_down <= 1'b0;
        end else begin
          level <= level - 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/rgb_status_leds.sv
// RGB status-LED bank: per-LED colour/mode config with global PWM dimming and blink/breathe.
// Define RGB_LEDS_BREATHE_EN for the breathe ramp; otherwise BREATHE behaves as ON.
module rgb_status_leds
  import rgb_leds_pkg::*;
#(
  parameter int N_LEDS    = 8,
  parameter int PWM_BITS  = 4,
  parameter int BLINK_DIV = 50000000,
  parameter int IDX_W     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [IDX_W-1:0]    WR_IDX,
  input  logic [2:0]          WR_COLOR,
  input  logic [1:0]          WR_MODE,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic [N_LEDS-1:0]   LED_R,
  output logic [N_LEDS-1:0]   LED_G,
  output logic [N_LEDS-1:0]   LED_B
);

  led_cfg_t            cfg [N_LEDS];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blink_phase;
  logic                pwm_on;
  logic                breathe_on;
  logic [N_LEDS-1:0]   lit;

`ifdef RGB_LEDS_BREATHE_EN
  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] breathe_duty;

  rgb_pwm_timebase #(
    .PWM_BITS  (PWM_BITS),
    .BLINK_DIV (BLINK_DIV)
  ) u_timebase (
    .clk         (CLK),
    .rst         (RST),
    .pwm_cnt     (pwm_cnt),
    .blink_phase (blink_phase),
    .level       (level)
  );

  assign breathe_duty = (level < BRIGHT) ? level : BRIGHT;
  assign breathe_on   = (pwm_cnt < breathe_duty);
`else
  rgb_pwm_timebase #(
    .PWM_BITS  (PWM_BITS),
    .BLINK_DIV (BLINK_DIV)
  ) u_timebase (
    .clk         (CLK),
    .rst         (RST),
    .pwm_cnt     (pwm_cnt),
    .blink_phase (blink_phase)
  );

  assign breathe_on = pwm_on;
`endif

  assign pwm_on = (pwm_cnt < BRIGHT);

  // Out-of-range indices match no LED, so such writes fall through untouched
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_LEDS; i++) begin
        cfg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (WR_EN && (32'(WR_IDX) == i)) begin
          cfg[i] <= '{color: WR_COLOR, mode: led_mode_t'(WR_MODE)};
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      lit[i] = 1'b0;
      case (cfg[i].mode)
        MODE_OFF:     lit[i] = 1'b0;
        MODE_ON:      lit[i] = pwm_on;
        MODE_BLINK:   lit[i] = pwm_on & blink_phase;
        MODE_BREATHE: lit[i] = breathe_on;
        default:      lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      LED_R <= '0;
      LED_G <= '0;
      LED_B <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        LED_R[i] <= lit[i] & cfg[i].color[0];
        LED_G[i] <= lit[i] & cfg[i].color[1];
        LED_B[i] <= lit[i] & cfg[i].color[2];
      end
    end
  end

endmodule

// File: tb/tb_rgb_status_leds.sv
// Self-checking bench for rgb_status_leds: directed scenarios then randomized traffic,
// compared against a time-based reference model (honours RGB_LEDS_BREATHE_EN).
module tb_rgb_status_leds;

  localparam int N_LEDS    = 4;
  localparam int PWM_BITS  = 2;
  localparam int BLINK_DIV = 4;
  localparam int IDX_W     = 3;
  localparam int PERIOD    = (1 << PWM_BITS) - 1;
  localparam int LVL_MAX   = (1 << PWM_BITS) - 1;
  localparam int OUT_W     = 3 * N_LEDS;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic                WR_EN = 1'b0;
  logic [IDX_W-1:0]    WR_IDX = '0;
  logic [2:0]          WR_COLOR = '0;
  logic [1:0]          WR_MODE = '0;
  logic [PWM_BITS-1:0] BRIGHT = '0;
  logic [N_LEDS-1:0]   LED_R;
  logic [N_LEDS-1:0]   LED_G;
  logic [N_LEDS-1:0]   LED_B;

  int m_color [N_LEDS];
  int m_mode  [N_LEDS];
  int t_run  = 0;
  int checks = 0;
  int errors = 0;

  rgb_status_leds #(
    .N_LEDS    (N_LEDS),
    .PWM_BITS  (PWM_BITS),
    .BLINK_DIV (BLINK_DIV),
    .IDX_W     (IDX_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_EN    (WR_EN),
    .WR_IDX   (WR_IDX),
    .WR_COLOR (WR_COLOR),
    .WR_MODE  (WR_MODE),
    .BRIGHT   (BRIGHT),
    .LED_R    (LED_R),
    .LED_G    (LED_G),
    .LED_B    (LED_B)
  );

  always #5 CLK = ~CLK;

  // Expected {B,G,R} from clocks elapsed since reset: PWM position, blink half-period
  // number and triangle breathe level all follow from t_run by plain arithmetic.
  function automatic logic [OUT_W-1:0] model_out(input int br);
    int pc, step, pos, lvl, duty;
    bit phase, on;
    logic [N_LEDS-1:0] r, g, b;
    pc    = t_run % PERIOD;
    step  = t_run / BLINK_DIV;
    phase = ((step % 2) == 0);
    pos   = step % (2 * (LVL_MAX + 1));
    lvl   = (pos <= LVL_MAX) ? pos : (2 * LVL_MAX + 1 - pos);
    for (int i = 0; i < N_LEDS; i++) begin
      duty = 0;
      case (m_mode[i])
        1: duty = br;
        2: duty = phase ? br : 0;
`ifdef RGB_LEDS_BREATHE_EN
        3: duty = (lvl < br) ? lvl : br;
`else
        3: duty = br;
`endif
        default: duty = 0;
      endcase
      on   = (pc < duty);
      r[i] = on && ((m_color[i] & 1) != 0);
      g[i] = on && ((m_color[i] & 2) != 0);
      b[i] = on && ((m_color[i] & 4) != 0);
    end
    return {b, g, r};
  endfunction

  task automatic check_output(input string tag, input logic [OUT_W-1:0] observed,
                              input logic [OUT_W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (t=%0d)", tag, observed, expected, t_run);
    end
  endtask

  task automatic apply_stimulus(input logic en, input int idx, input int color,
                                input int mode, input int br);
    WR_EN    = en;
    WR_IDX   = IDX_W'(idx);
    WR_COLOR = 3'(color);
    WR_MODE  = 2'(mode);
    BRIGHT   = PWM_BITS'(br);
  endtask

  // One clock: model follows the edge, then the registered outputs are compared
  task automatic step_check(input string tag);
    logic [OUT_W-1:0] expected;
    @(posedge CLK);
    if (RST) begin
      expected = '0;
      t_run    = 0;
      for (int i = 0; i < N_LEDS; i++) begin
        m_color[i] = 0;
        m_mode[i]  = 0;
      end
    end else begin
      expected = model_out(int'(BRIGHT));
      if (WR_EN && (int'(WR_IDX) < N_LEDS)) begin
        m_color[int'(WR_IDX)] = int'(WR_COLOR);
        m_mode[int'(WR_IDX)]  = int'(WR_MODE);
      end
      t_run++;
    end
    #1;
    check_output(tag, {LED_B, LED_G, LED_R}, expected);
  endtask

  initial begin
    for (int i = 0; i < N_LEDS; i++) begin
      m_color[i] = 0;
      m_mode[i]  = 0;
    end

    RST = 1'b1;
    apply_stimulus(1'b0, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++) step_check("reset");
    RST = 1'b0;
    for (int i = 0; i < 10; i++) step_check("idle");

    $display("[TB] red ON at idx1");
    apply_stimulus(1'b1, 1, 1, 1, 3);
    step_check("on_write");
    apply_stimulus(1'b0, 1, 1, 1, 3);
    step_check("on_settle");
    check_output("on_const", {LED_B, LED_G, LED_R}, {8'h00, 4'b0010});
    for (int i = 0; i < 8; i++) step_check("on_full");
    BRIGHT = 2'd1;
    for (int i = 0; i < 9; i++) step_check("on_dim1");
    BRIGHT = 2'd0;
    for (int i = 0; i < 6; i++) step_check("on_dark");

    $display("[TB] blue BLINK at idx2");
    apply_stimulus(1'b1, 2, 4, 2, 3);
    step_check("blink_write");
    apply_stimulus(1'b0, 2, 4, 2, 3);
    for (int i = 0; i < 20; i++) step_check("blink");

    apply_stimulus(1'b1, 5, 7, 1, 3);
    step_check("oob_write");
    apply_stimulus(1'b0, 0, 0, 0, 3);
    for (int i = 0; i < 4; i++) step_check("oob_after");
    RST = 1'b1;
    apply_stimulus(1'b1, 3, 7, 1, 3);
    step_check("mid_reset");
    RST = 1'b0;
    apply_stimulus(1'b0, 0, 0, 0, 3);
    for (int i = 0; i < 4; i++) step_check("post_reset");

    $display("[TB] white BREATHE at idx0");
    apply_stimulus(1'b1, 0, 7, 3, 3);
    step_check("breathe_write");
    apply_stimulus(1'b0, 0, 0, 0, 3);
    for (int i = 0; i < 40; i++) step_check("breathe");
    BRIGHT = 2'd2;
    for (int i = 0; i < 24; i++) step_check("breathe_cap");

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      RST = ($urandom_range(0, 99) == 0);
      apply_stimulus(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : int'(BRIGHT));
      step_check("random");
    end
    RST = 1'b0;
    WR_EN = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
